bat_amateur_mem_dump: RTL and testbench
=======================================

# bat_amateur_mem_dump

Program-memory readback engine for the BatAmateur CPU. It is the reading counterpart of the bench/loader path that writes a program into RAM over RAM_EN/RAM_RW/ADDRESS_BUS while the CPU is held in HALT. On a START pulse it holds the CPU halted and reads an inclusive address range from RAM. It streams each word out over a valid/ready handshake and reports a running 16-bit checksum, so a loaded image can be verified or dumped.

## Interface
- ADDRESS_WIDTH, 16, width of RAM address and range registers
- DATA_WIDTH, 16, width of RAM data words and checksum

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-low reset
- START  input  1  one-cycle request; sampled only in IDLE
- ABORT  input  1  cancels a dump in progress; ignored in IDLE
- START_ADDR  input  ADDRESS_WIDTH  first address, captured with START
- END_ADDR  input  ADDRESS_WIDTH  last address (inclusive), captured with START
- HALT  output  1  holds CPU stopped while the dump owns the RAM
- RAM_EN  output  1  RAM enable
- RAM_RW  output  1  1 = read, 0 = write; this block only reads
- ADDRESS_BUS  output  ADDRESS_WIDTH  RAM address
- RAM_DATA  input  DATA_WIDTH  RAM read data, valid the cycle after the address cycle
- DUMP_VALID  output  1  DUMP_DATA/DUMP_ADDR hold a word
- DUMP_READY  input  1  consumer accepts the word
- DUMP_DATA  output  DATA_WIDTH  word read
- DUMP_ADDR  output  ADDRESS_WIDTH  address of DUMP_DATA
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle pulse on normal completion
- CHECKSUM  output  DATA_WIDTH  sum of all words transferred in the current/last dump, modulo 2^DATA_WIDTH

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE: all bus outputs 0. START=1 captures START_ADDR into addr and END_ADDR into end, clears CHECKSUM, then moves to ISSUE.
- ISSUE: RAM_EN=1, RAM_RW=1, ADDRESS_BUS=addr. Always moves to WAIT.
- WAIT: RAM_EN=0. Captures RAM_DATA into DUMP_DATA and addr into DUMP_ADDR, then moves to PRESENT.
- PRESENT: DUMP_VALID=1, and DUMP_DATA/DUMP_ADDR stay stable until transfer. A transfer is DUMP_VALID&DUMP_READY at a rising edge.
- On transfer: CHECKSUM += DUMP_DATA.
  - If addr==end, move to FINISH.
  - Otherwise addr = addr+1 and move to ISSUE.
- FINISH: DONE=1 for one cycle, then IDLE.
- HALT=1 in ISSUE, WAIT, PRESENT and FINISH; HALT=0 in IDLE.
- RAM_RW=1 whenever RAM_EN=1. RAM_EN=0 and ADDRESS_BUS=0 outside ISSUE.
- Address arithmetic is modulo 2^ADDRESS_WIDTH.
  - If END_ADDR < START_ADDR, the range wraps through all-ones to 0.
  - Word count = ((END_ADDR-START_ADDR) mod 2^ADDRESS_WIDTH)+1.
  - START_ADDR==END_ADDR reads exactly one word.
- START outside IDLE is ignored; the range registers do not change.
- ABORT in any non-IDLE state: next state is IDLE, DONE is not pulsed, CHECKSUM keeps its partial sum.
  - ABORT in the same cycle as a PRESENT transfer: abort wins; no checksum update and no further reads.
- DUMP_READY outside PRESENT has no effect.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE; HALT, RAM_EN, RAM_RW, BUSY, DONE, DUMP_VALID=0; ADDRESS_BUS, DUMP_DATA, DUMP_ADDR, CHECKSUM=0.
- Reset mid-dump aborts immediately with the values above. No DONE pulse.
- The START edge is cycle 0.
  - Cycle 1: ISSUE, with HALT and RAM_EN high.
  - Cycle 2: WAIT.
  - Cycle 3: DUMP_VALID high at the earliest.
- With DUMP_READY held high, each word takes 3 cycles (ISSUE, WAIT, PRESENT).
  - An N-word dump shows DONE at cycle 3N+1.
  - HALT falls at cycle 3N+2.
- Every stall cycle with DUMP_READY=0 extends PRESENT by one cycle. RAM is not re-read during a stall.
- RAM read latency is fixed at one cycle: data for the ISSUE address is sampled at the WAIT→PRESENT edge.
- CHECKSUM updates on the transfer edge and is stable in IDLE.

## Test plan
- Normal dump: RAM[0x10..0x12]=0,1,5; START with 0x0010..0x0012, DUMP_READY=1.
  - Expect words (0x10,0), (0x11,1), (0x12,5).
  - Expect CHECKSUM=6 and DONE at cycle 10.
  - Expect HALT high on cycles 1–10.
- Backpressure: same range, DUMP_READY=0 for 4 cycles on the second word.
  - Expect DUMP_DATA=1 held stable throughout.
  - Expect exactly one RAM_EN pulse per address, DONE at cycle 14, CHECKSUM=6.
- Wrap and single word: START 0xFFFE..0x0001 reads addresses FFFE, FFFF, 0000, 0001 (4 words).
  - START 0x0005..0x0005 reads one word, with DONE at cycle 4.
- Checksum overflow: RAM[0..1]=0xFFFF,0x0003 gives CHECKSUM=0x0002.
- START ignored: START pulsed again with a different range while BUSY. Expect the original range unaffected.
- ABORT/reset: ABORT during the second word's PRESENT.
  - Expect IDLE next cycle, HALT=0, no DONE, CHECKSUM equal to the first word.
  - Repeat with RESET=0 mid-WAIT: all outputs 0 asynchronously.

Source files
------------

// File: rtl/bat_amateur_mem_dump.sv
// Program-memory readback engine for the BatAmateur CPU: halts the CPU, reads an
// inclusive (wrapping) address range from RAM and streams it out with a running checksum.
module bat_amateur_mem_dump #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [ADDRESS_WIDTH-1:0] START_ADDR,
    input  logic [ADDRESS_WIDTH-1:0] END_ADDR,
    output logic                     HALT,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
    input  logic [DATA_WIDTH-1:0]    RAM_DATA,
    output logic                     DUMP_VALID,
    input  logic                     DUMP_READY,
    output logic [DATA_WIDTH-1:0]    DUMP_DATA,
    output logic [ADDRESS_WIDTH-1:0] DUMP_ADDR,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [DATA_WIDTH-1:0]    CHECKSUM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] end_addr;
    logic                     xfer;
    logic                     last_word;

    // ABORT outranks a handshake landing on the same edge.
    assign xfer      = (state == S_PRESENT) && DUMP_READY && !ABORT;
    assign last_word = (addr == end_addr);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flip-flops.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (state != S_IDLE && ABORT) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (START) state_next = S_ISSUE;
                S_ISSUE:   state_next = S_WAIT;
                S_WAIT:    state_next = S_PRESENT;
                S_PRESENT: if (xfer) state_next = last_word ? S_FINISH : S_ISSUE;
                S_FINISH:  state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        HALT        = (state != S_IDLE);
        BUSY        = (state != S_IDLE);
        RAM_EN      = (state == S_ISSUE);
        RAM_RW      = (state == S_ISSUE);
        ADDRESS_BUS = '0;
        DUMP_VALID  = (state == S_PRESENT);
        DONE        = (state == S_FINISH);
        if (state == S_ISSUE) ADDRESS_BUS = addr;
    end

    // NOTE: the datapath registers are plain flops (not a memory array), so they
    // all take the asynchronous reset and read back as zero straight out of reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr      <= '0;
            end_addr  <= '0;
            DUMP_DATA <= '0;
            DUMP_ADDR <= '0;
            CHECKSUM  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        addr     <= START_ADDR;
                        end_addr <= END_ADDR;
                        CHECKSUM <= '0;
                    end
                end
                S_WAIT: begin
                    // RAM answers one cycle after the ISSUE address cycle.
                    DUMP_DATA <= RAM_DATA;
                    DUMP_ADDR <= addr;
                end
                S_PRESENT: begin
                    if (xfer) begin
                        CHECKSUM <= CHECKSUM + DUMP_DATA;
                        if (!last_word) addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bat_amateur_mem_dump.sv
// Directed bench for bat_amateur_mem_dump: a RAM model, a range/queue scoreboard
// checked every cycle, and hand-computed timing and checksum expectations.
module tb_bat_amateur_mem_dump;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        DUMP_READY = 1'b0;
    logic [15:0] START_ADDR = '0;
    logic [15:0] END_ADDR = '0;
    logic [15:0] RAM_DATA = '0;
    logic        HALT, RAM_EN, RAM_RW, DUMP_VALID, BUSY, DONE;
    logic [15:0] ADDRESS_BUS, DUMP_DATA, DUMP_ADDR, CHECKSUM;

    bat_amateur_mem_dump dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .START_ADDR(START_ADDR), .END_ADDR(END_ADDR),
        .HALT(HALT), .RAM_EN(RAM_EN), .RAM_RW(RAM_RW), .ADDRESS_BUS(ADDRESS_BUS),
        .RAM_DATA(RAM_DATA), .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY),
        .DUMP_DATA(DUMP_DATA), .DUMP_ADDR(DUMP_ADDR), .BUSY(BUSY), .DONE(DONE),
        .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    logic [15:0] mem [0:65535];
    word_t       exp_q[$];
    logic [15:0] read_log[$];
    logic [15:0] model_sum = '0;
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          base = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM with one cycle of read latency; garbage when not addressed.
    always @(posedge CLK) RAM_DATA <= (RAM_EN && RAM_RW) ? mem[ADDRESS_BUS] : 16'hDEAD;

    // Scoreboard: the words a dump must produce, in order, plus the running sum.
    always @(negedge CLK) begin
        word_t       w;
        logic [15:0] a;
        logic [15:0] span;
        if (!RESET) begin
            exp_q.delete();
            model_sum = '0;
            check("reset_ctl", {HALT, RAM_EN, RAM_RW, BUSY, DONE, DUMP_VALID}, 0);
            check("reset_bus", {ADDRESS_BUS, DUMP_DATA, DUMP_ADDR}, 0);
            check("reset_sum", CHECKSUM, 0);
        end else begin
            check("checksum", CHECKSUM, model_sum);
            check("halt_busy", HALT, BUSY);
            check("rw_en", RAM_RW, RAM_EN);
            if (!RAM_EN) check("addr_idle", ADDRESS_BUS, 0);
            else if (exp_q.size() == 0) check("read_unexpected", RAM_EN, 0);
            else begin
                check("read_addr", ADDRESS_BUS, exp_q[0].addr);
                read_log.push_back(ADDRESS_BUS);
            end
            if (DUMP_VALID) begin
                if (exp_q.size() == 0) check("valid_unexpected", DUMP_VALID, 0);
                else check("dump_word", {DUMP_ADDR, DUMP_DATA}, exp_q[0]);
            end
            if (!BUSY) check("idle_quiet", {DUMP_VALID, DONE, RAM_EN}, 0);

            if (BUSY && ABORT) exp_q.delete();
            else if (DUMP_VALID && DUMP_READY && exp_q.size() > 0) begin
                model_sum += exp_q[0].data;
                void'(exp_q.pop_front());
            end
            if (!BUSY && START) begin
                model_sum = '0;
                exp_q.delete();
                span = END_ADDR - START_ADDR;
                for (int i = 0; i <= int'(span); i++) begin
                    a = START_ADDR + 16'(i);
                    w.addr = a;
                    w.data = mem[a];
                    exp_q.push_back(w);
                end
            end
        end
    end

    // Cycle n is the state after the n-th edge counted from the START edge (cycle 0).
    task automatic run_dump(input logic [15:0] s, input logic [15:0] e,
                            input int stall_at, input int abort_at, input int ign_at,
                            output int done_at, output int halt_fall, output int valid_cycles);
        int rel;
        @(posedge CLK); #1;
        START_ADDR = s;
        END_ADDR = e;
        START = 1'b1;
        DUMP_READY = 1'b1;
        base = cyc;
        done_at = -1;
        halt_fall = -1;
        valid_cycles = 0;
        read_log.delete();
        for (int k = 0; k < 300 && halt_fall < 0; k++) begin
            @(posedge CLK); #1;
            rel = cyc - base;
            START = 1'b0;
            ABORT = 1'b0;
            if (rel == ign_at) begin
                START = 1'b1;
                START_ADDR = 16'h0020;
                END_ADDR = 16'h0025;
            end
            if (rel == abort_at) ABORT = 1'b1;
            if (stall_at >= 0) DUMP_READY = !(rel >= stall_at && rel < stall_at + 4);
            @(negedge CLK);
            if (DONE) done_at = rel;
            if (DUMP_VALID) valid_cycles++;
            if (!HALT) halt_fall = rel;
        end
        if (halt_fall < 0) check("dump_timeout", HALT, 0);
    endtask

    task automatic check_reads(input string name, input logic [15:0] s, input int n);
        logic [15:0] a;
        check({name, "_read_count"}, read_log.size(), n);
        for (int i = 0; i < n && i < read_log.size(); i++) begin
            a = s + 16'(i);
            check({name, "_read_addr"}, read_log[i], a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, h, v;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[16'h0010] = 16'h0000;
        mem[16'h0011] = 16'h0001;
        mem[16'h0012] = 16'h0005;
        mem[16'hFFFE] = 16'h1111;
        mem[16'hFFFF] = 16'h2222;
        mem[16'h0000] = 16'h3333;
        mem[16'h0001] = 16'h4444;
        mem[16'h0005] = 16'h0077;

        repeat (2) @(negedge CLK);
        #2 RESET = 1'b1;

        // Normal three-word dump.
        run_dump(16'h0010, 16'h0012, -1, -1, -1, d, h, v);
        check("normal_done", d, 10);
        check("normal_halt_fall", h, 11);
        check("normal_valid_cycles", v, 3);
        check("normal_sum", CHECKSUM, 16'h0006);
        check("normal_drained", exp_q.size(), 0);
        check_reads("normal", 16'h0010, 3);

        // Four stall cycles on the second word.
        run_dump(16'h0010, 16'h0012, 6, -1, -1, d, h, v);
        check("stall_done", d, 14);
        check("stall_halt_fall", h, 15);
        check("stall_valid_cycles", v, 7);
        check("stall_sum", CHECKSUM, 16'h0006);
        check_reads("stall", 16'h0010, 3);

        // Range wrapping through 0xFFFF.
        run_dump(16'hFFFE, 16'h0001, -1, -1, -1, d, h, v);
        check("wrap_done", d, 13);
        check("wrap_sum", CHECKSUM, 16'hAAAA);
        check_reads("wrap", 16'hFFFE, 4);

        // Single word.
        run_dump(16'h0005, 16'h0005, -1, -1, -1, d, h, v);
        check("single_done", d, 4);
        check("single_halt_fall", h, 5);
        check("single_sum", CHECKSUM, 16'h0077);
        check_reads("single", 16'h0005, 1);

        // Checksum wraps modulo 2^16.
        mem[16'h0000] = 16'hFFFF;
        mem[16'h0001] = 16'h0003;
        run_dump(16'h0000, 16'h0001, -1, -1, -1, d, h, v);
        check("ovf_done", d, 7);
        check("ovf_sum", CHECKSUM, 16'h0002);

        // A second START while busy must not disturb the running range.
        run_dump(16'h0010, 16'h0012, -1, -1, 2, d, h, v);
        check("ign_done", d, 10);
        check("ign_sum", CHECKSUM, 16'h0006);
        check_reads("ign", 16'h0010, 3);

        // ABORT coinciding with the second word's handshake.
        mem[16'h0010] = 16'h0042;
        run_dump(16'h0010, 16'h0012, -1, 6, -1, d, h, v);
        check("abort_no_done", d, -1);
        check("abort_halt_fall", h, 7);
        check("abort_sum", CHECKSUM, 16'h0042);
        repeat (3) @(negedge CLK);
        check("abort_quiet_busy", BUSY, 0);
        check_reads("abort", 16'h0010, 2);

        // Asynchronous reset during the second word's WAIT.
        @(posedge CLK); #1;
        START_ADDR = 16'h0010;
        END_ADDR = 16'h0012;
        START = 1'b1;
        DUMP_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        check("pre_reset_sum", CHECKSUM, 16'h0042);
        check("pre_reset_wait", {BUSY, RAM_EN, DUMP_VALID}, 3'b100);
        RESET = 1'b0;
        #1;
        check("async_reset_ctl", {HALT, RAM_EN, RAM_RW, BUSY, DONE, DUMP_VALID}, 0);
        check("async_reset_bus", {ADDRESS_BUS, DUMP_DATA, DUMP_ADDR}, 0);
        check("async_reset_sum", CHECKSUM, 0);
        @(posedge CLK); #2;
        RESET = 1'b1;

        // Recovery after reset.
        run_dump(16'h0012, 16'h0012, -1, -1, -1, d, h, v);
        check("recover_done", d, 4);
        check("recover_sum", CHECKSUM, 16'h0005);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
